// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: drives the PC to instruction memory and buffers the returned
// {pc, inst} pairs in a small FIFO toward decode. Redirects abort the pending read and flush.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
  parameter int unsigned FIFO_DEPTH  = 2,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_stall,
  input  logic [31:0] imem_r_data,
  input  logic [1:0]  imem_r_data_status,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic [31:0] fetch_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  logic [31:0]     pc_q, pc_d;
  logic [31:0]     fc_q, fc_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [31:0] pc_mem   [FIFO_DEPTH];
  logic [31:0] inst_mem [FIFO_DEPTH];

  logic full;
  logic push;
  logic pop;

  // Memory latency only shapes external timing; redirect low bits are forced to word alignment.
  logic unused_bits;
  assign unused_bits = ^{redirect_pc[1:0], MEM_LATENCY};

  assign full       = (cnt_q == CntFull);
  assign push       = (imem_r_data_status == 2'b10) && !redirect_valid && !full;
  assign pop        = out_valid && out_ready;
  assign imem_stall = rst | redirect_valid | full;
  assign imem_addr  = pc_q;

  assign out_valid   = (cnt_q != '0);
  assign out_pc      = out_valid ? pc_mem[rd_ptr_q]   : 32'h0;
  assign out_inst    = out_valid ? inst_mem[rd_ptr_q] : 32'h0;
  assign fetch_count = fc_q;

  always_comb begin
    pc_d     = pc_q;
    fc_d     = fc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (redirect_valid) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        fc_d     = fc_q + 32'd1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      fc_q     <= 32'h0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      fc_q     <= fc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pc_mem[wr_ptr_q]   <= pc_q;
      inst_mem[wr_ptr_q] <= imem_r_data;
    end
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Initiator side of the instruction-memory interface. Holds the PC, presents it to the instruction memory, and captures the word when the memory reports status 2'b10. Buffers fetched {pc, inst} pairs in a small FIFO toward decode with a valid/ready handshake. Handles branch/jump redirects by aborting the in-flight read through the memory's stall input and flushing the buffer.

Parameters:
RESET_PC, 32'hBFC0_0000, PC loaded on reset.
FIFO_DEPTH, 2, entries in the fetch buffer; power of two, at least 2.
MEM_LATENCY, 1, memory latency_cycles setting; used only for bench timing checks, no RTL effect.

Ports:
clk  in  1  clock; all state changes on posedge.
rst  in  1  synchronous, active-high reset.
imem_addr  out  32  fetch address to memory; equals pc.
imem_stall  out  1  memory stall/abort; drives memory `stall`.
imem_r_data  in  32  memory read data.
imem_r_data_status  in  2  memory status: 0 idle, 1 pending, 2 data valid.
redirect_valid  in  1  one-cycle pulse: flush and refetch from redirect_pc.
redirect_pc  in  32  new fetch PC.
out_valid  out  1  buffer head valid toward decode.
out_inst  out  32  head instruction; 0 when empty.
out_pc  out  32  head PC; 0 when empty.
out_ready  in  1  decode accepts head this cycle.
fetch_count  out  32  number of instructions pushed since reset; wraps modulo 2^32.

Behaviour:
- Reset (sync, rst high at posedge):
  - pc <= RESET_PC.
  - FIFO emptied.
  - fetch_count <= 0.
- Outputs after reset: out_valid=0, out_inst=0, out_pc=0, imem_addr=RESET_PC.
- imem_stall (combinational) = rst | redirect_valid | (count == FIFO_DEPTH).
- imem_addr = pc at all times. pc changes only on a push or a redirect, so the address is stable while a read is pending.
- Response accept: imem_r_data_status == 2'b10 and redirect_valid == 0.
  - Push {pc, imem_r_data}.
  - pc <= pc + 4; 32-bit wrap, 32'hFFFF_FFFC -> 0.
  - fetch_count++.
- Status 2'b00, 2'b01 and 2'b11: no push. 2'b11 is treated as not-valid.
- No response can arrive when the FIFO is full, because stall holds the memory at status 0. If status 2'b10 arrives while count == FIFO_DEPTH, the response is dropped and pc is unchanged; the bench flags this as a protocol error.
- Pop: out_valid & out_ready advances the head.
- Simultaneous push and pop: count unchanged, ordering preserved.
- Redirect (redirect_valid=1 at posedge) has priority over everything except rst:
  - pc <= {redirect_pc[31:2], 2'b00}.
  - FIFO emptied.
  - A concurrent status-2'b10 response is discarded.
  - A concurrent pop is ignored.
  - fetch_count is unchanged.
  - imem_stall is high in that cycle, so the memory returns to status 0; fetching of the new pc starts the next cycle.
- Back-to-back redirects: the last one wins; each flushes.
- Latency: with memory latency L, the first word is at out_valid L+3 cycles after the first cycle with imem_stall low. Sustained fetch rate is one instruction per L+3 cycles (memory cycles 0 -> 1 -> 2 -> 0).
- When full, imem_stall stays high until a pop frees an entry. The memory then restarts from status 0.
- Out-of-range FIFO pointers wrap modulo FIFO_DEPTH; count is a separate register of width log2(FIFO_DEPTH)+1.

Test Plan:
1. Reset release, memory L=1, mem[0xBFC00000]=0x24080001, out_ready=1 -> out_valid rises 4 cycles after first unstalled cycle with out_inst=0x24080001, out_pc=0xBFC00000; imem_addr then 0xBFC00004.
2. out_ready=0, run 20 cycles -> exactly 2 entries (PCs 0xBFC00000, 0xBFC00004), imem_stall=1, fetch_count=2, imem_addr=0xBFC00008. Raise out_ready for 1 cycle -> fetch resumes and the next push has out_pc 0xBFC00008.
3. Redirect pulse to 0x80001003 in the same cycle as status 2'b10 -> response dropped, FIFO empty, out_valid=0 next cycle, next pushed out_pc=0x80001000.
4. redirect_pc=0xFFFFFFFC, two fetches -> out_pc sequence 0xFFFFFFFC then 0x00000000.
5. rst asserted mid-read (status 2'b01) with FIFO holding 1 entry -> next cycle out_valid=0, pc=0xBFC00000, fetch_count=0, memory status 0.
6. Random out_ready/redirect stress, 10k cycles, against a reference PC model -> every popped (pc, inst) matches memory contents and PC order; no push is observed while full.
